// File: rtl/bcd_scan_counter.sv
// bcd_scan_counter: multi-digit BCD up/down counter with a prescaled count
// tick and a free-running scan that presents one digit per slot to the
// 7-segment decoder, together with a one-hot position select.
module bcd_scan_counter #(
    parameter int NUM_DIGITS = 4,
    parameter int TICK_DIV   = 50000,
    parameter int SCAN_DIV   = 1000
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    en,
    input  logic                    up,
    input  logic                    clear,
    input  logic                    load,
    input  logic [4*NUM_DIGITS-1:0] load_value,
    output logic [3:0]              number,
    output logic [NUM_DIGITS-1:0]   digit_sel,
    output logic [4*NUM_DIGITS-1:0] count_value,
    output logic                    carry_pulse
);

    localparam int CW = 4 * NUM_DIGITS;
    localparam int TW = $clog2(TICK_DIV);
    localparam int SW = $clog2(SCAN_DIV);
    localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

    logic [TW-1:0]         r_tick_cnt;
    logic [SW-1:0]         r_scan_cnt;
    logic [IW-1:0]         r_scan_idx;
    logic [CW-1:0]         r_count;
    logic                  r_carry;
    logic [3:0]            r_number;
    logic [NUM_DIGITS-1:0] r_digit_sel;

    logic                  w_tick;
    logic [CW-1:0]         w_load_sat;
    logic [CW-1:0]         w_step_val;
    logic                  w_chain;
    logic                  w_wrap;
    logic [CW-1:0]         w_count_next;
    logic                  w_scan_wrap;
    logic [IW-1:0]         w_idx_next;
    logic [3:0]            w_number_next;
    logic [NUM_DIGITS-1:0] w_sel_next;

    // Count tick fires on the last prescaler state while enabled
    always_comb begin
        w_tick = en && (r_tick_cnt == TW'(TICK_DIV - 1));
    end

    // Saturate out-of-range load nibbles to 9
    always_comb begin
        w_load_sat = '0;
        for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
            w_load_sat[i*4 +: 4] = (load_value[i*4 +: 4] > 4'd9) ? 4'd9 : load_value[i*4 +: 4];
        end
    end

    // Ripple BCD increment/decrement; a carry out of the top digit is a wrap
    always_comb begin
        w_step_val = r_count;
        w_chain    = 1'b1;
        for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
            if (w_chain) begin
                if (up) begin
                    if (r_count[i*4 +: 4] == 4'd9) begin
                        w_step_val[i*4 +: 4] = 4'd0;
                    end else begin
                        w_step_val[i*4 +: 4] = r_count[i*4 +: 4] + 4'd1;
                        w_chain = 1'b0;
                    end
                end else begin
                    if (r_count[i*4 +: 4] == 4'd0) begin
                        w_step_val[i*4 +: 4] = 4'd9;
                    end else begin
                        w_step_val[i*4 +: 4] = r_count[i*4 +: 4] - 4'd1;
                        w_chain = 1'b0;
                    end
                end
            end
        end
        w_wrap = w_chain;
    end

    // Next count with priority clear > load > tick step
    always_comb begin
        w_count_next = r_count;
        if (clear) begin
            w_count_next = '0;
        end else if (load) begin
            w_count_next = w_load_sat;
        end else if (w_tick) begin
            w_count_next = w_step_val;
        end
    end

    // Next scan position and the digit shown there, taken from the next
    // count so number tracks count_value on the same edge
    always_comb begin
        w_scan_wrap   = (r_scan_cnt == SW'(SCAN_DIV - 1));
        w_idx_next    = r_scan_idx;
        w_sel_next    = '0;
        w_number_next = '0;
        if (w_scan_wrap) begin
            w_idx_next = (r_scan_idx == IW'(NUM_DIGITS - 1)) ? '0 : r_scan_idx + IW'(1);
        end
        for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
            if (w_idx_next == IW'(i)) begin
                w_sel_next[i] = 1'b1;
                w_number_next = w_count_next[i*4 +: 4];
            end
        end
    end

    // Tick prescaler: advances only while enabled, restarted by clear/load
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_tick_cnt <= '0;
        end else if (clear || load) begin
            r_tick_cnt <= '0;
        end else if (en) begin
            r_tick_cnt <= w_tick ? '0 : r_tick_cnt + TW'(1);
        end
    end

    // Count register and one-cycle wrap pulse
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= '0;
            r_carry <= 1'b0;
        end else begin
            r_count <= w_count_next;
            r_carry <= !clear && !load && w_tick && w_wrap;
        end
    end

    // Free-running scan prescaler, index and registered display outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_scan_cnt  <= '0;
            r_scan_idx  <= '0;
            r_digit_sel <= NUM_DIGITS'(1);
            r_number    <= '0;
        end else begin
            r_scan_cnt  <= w_scan_wrap ? '0 : r_scan_cnt + SW'(1);
            r_scan_idx  <= w_idx_next;
            r_digit_sel <= w_sel_next;
            r_number    <= w_number_next;
        end
    end

    assign count_value = r_count;
    assign carry_pulse = r_carry;
    assign number      = r_number;
    assign digit_sel   = r_digit_sel;

endmodule

// File: tb/tb_bcd_scan_counter.sv
// Self-checking bench for bcd_scan_counter using a decimal-integer model.
module tb_bcd_scan_counter;

    localparam int N   = 4;
    localparam int TD  = 4;
    localparam int SD  = 2;
    localparam int MOD = 10000;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic           en = 1'b0;
    logic           up = 1'b1;
    logic           clear = 1'b0;
    logic           load = 1'b0;
    logic [4*N-1:0] load_value = '0;
    logic [3:0]     number;
    logic [N-1:0]   digit_sel;
    logic [4*N-1:0] count_value;
    logic           carry_pulse;

    int n_checks = 0;
    int n_fail   = 0;

    // model state: count as a plain decimal integer, enabled-cycle prescaler,
    // number of clock edges since reset for the scan position
    int m_count = 0;
    int m_tick  = 0;
    int m_cyc   = 0;
    bit m_carry = 1'b0;

    bcd_scan_counter #(
        .NUM_DIGITS(N),
        .TICK_DIV  (TD),
        .SCAN_DIV  (SD)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .en         (en),
        .up         (up),
        .clear      (clear),
        .load       (load),
        .load_value (load_value),
        .number     (number),
        .digit_sel  (digit_sel),
        .count_value(count_value),
        .carry_pulse(carry_pulse)
    );

    always #5 clk = ~clk;

    function automatic int bcd_to_int(input logic [4*N-1:0] v);
        int r = 0;
        int d;
        for (int i = N - 1; i >= 0; i--) begin
            d = int'(v[i*4 +: 4]);
            if (d > 9) d = 9;
            r = r * 10 + d;
        end
        return r;
    endfunction

    function automatic logic [4*N-1:0] int_to_bcd(input int x);
        logic [4*N-1:0] r = '0;
        int t = x;
        for (int i = 0; i < N; i++) begin
            r[i*4 +: 4] = 4'(t % 10);
            t = t / 10;
        end
        return r;
    endfunction

    function automatic int exp_idx();
        return (m_cyc / SD) % N;
    endfunction

    function automatic logic [N-1:0] exp_sel();
        return N'(1) << exp_idx();
    endfunction

    function automatic logic [3:0] exp_num();
        return 4'((m_count / (10 ** exp_idx())) % 10);
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_count = 0;
            m_tick  = 0;
            m_cyc   = 0;
            m_carry = 1'b0;
        end else begin
            m_carry = 1'b0;
            if (clear) begin
                m_count = 0;
                m_tick  = 0;
            end else if (load) begin
                m_count = bcd_to_int(load_value);
                m_tick  = 0;
            end else if (en) begin
                if (m_tick == TD - 1) begin
                    m_tick = 0;
                    if (up) begin
                        m_carry = (m_count == MOD - 1);
                        m_count = (m_count + 1) % MOD;
                    end else begin
                        m_carry = (m_count == 0);
                        m_count = (m_count + MOD - 1) % MOD;
                    end
                end else begin
                    m_tick++;
                end
            end
            m_cyc++;
        end
    end

    task automatic test_reset();
        rst_n = 1'b0;
        en = 1'b1;
        up = 1'b1;
        repeat (3) @(negedge clk);
        n_checks++;
        if (count_value !== 16'h0000 || digit_sel !== 4'b0001 || number !== 4'd0 || carry_pulse !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_hold: cnt=%h sel=%b num=%0d cp=%b required 0000 0001 0 0",
                     count_value, digit_sel, number, carry_pulse);
        end
        rst_n = 1'b1;
        for (int c = 1; c <= 12; c++) begin
            @(negedge clk);
            n_checks++;
            if (count_value !== int_to_bcd(m_count) || digit_sel !== exp_sel() ||
                number !== exp_num() || carry_pulse !== m_carry) begin
                n_fail++;
                $display("FAIL reset_count c=%0d: cnt=%h sel=%b num=%0d cp=%b required %h %b %0d %b",
                         c, count_value, digit_sel, number, carry_pulse,
                         int_to_bcd(m_count), exp_sel(), exp_num(), m_carry);
            end
            n_checks++;
            if (count_value !== 16'(c / 4)) begin
                n_fail++;
                $display("FAIL step_rate c=%0d: cnt=%h required %h", c, count_value, 16'(c / 4));
            end
        end
    endtask

    task automatic test_wrap_up();
        int carries = 0;
        load = 1'b1;
        load_value = 16'h9998;
        en = 1'b1;
        up = 1'b1;
        @(negedge clk);
        load = 1'b0;
        for (int c = 1; c <= 9; c++) begin
            @(negedge clk);
            if (carry_pulse === 1'b1) carries++;
            n_checks++;
            if (count_value !== int_to_bcd(m_count) || carry_pulse !== m_carry ||
                digit_sel !== exp_sel() || number !== exp_num()) begin
                n_fail++;
                $display("FAIL wrap_up c=%0d: cnt=%h cp=%b sel=%b num=%0d required %h %b %b %0d",
                         c, count_value, carry_pulse, digit_sel, number,
                         int_to_bcd(m_count), m_carry, exp_sel(), exp_num());
            end
            if (c == 8) begin
                n_checks++;
                if (count_value !== 16'h0000 || carry_pulse !== 1'b1) begin
                    n_fail++;
                    $display("FAIL wrap_up_end: cnt=%h cp=%b required 0000 1", count_value, carry_pulse);
                end
            end
        end
        n_checks++;
        if (carries != 1) begin
            n_fail++;
            $display("FAIL wrap_up_pulses: got %0d required 1", carries);
        end
    endtask

    task automatic test_down_hold();
        load = 1'b1;
        load_value = 16'h0001;
        en = 1'b1;
        up = 1'b0;
        @(negedge clk);
        load = 1'b0;
        for (int c = 1; c <= 28; c++) begin
            @(negedge clk);
            if (c == 8) en = 1'b0;
            n_checks++;
            if (count_value !== int_to_bcd(m_count) || carry_pulse !== m_carry ||
                digit_sel !== exp_sel() || number !== exp_num()) begin
                n_fail++;
                $display("FAIL down_hold c=%0d: cnt=%h cp=%b sel=%b num=%0d required %h %b %b %0d",
                         c, count_value, carry_pulse, digit_sel, number,
                         int_to_bcd(m_count), m_carry, exp_sel(), exp_num());
            end
        end
        n_checks++;
        if (count_value !== 16'h9999) begin
            n_fail++;
            $display("FAIL down_hold_end: cnt=%h required 9999", count_value);
        end
    endtask

    task automatic test_load_sat_clear();
        en = 1'b1;
        up = 1'b1;
        load = 1'b1;
        load_value = 16'hF3A2;
        @(negedge clk);
        load = 1'b0;
        n_checks++;
        if (count_value !== 16'h9392) begin
            n_fail++;
            $display("FAIL load_sat: cnt=%h required 9392", count_value);
        end
        repeat (2) @(negedge clk);
        clear = 1'b1;
        load = 1'b1;
        load_value = 16'h5555;
        @(negedge clk);
        clear = 1'b0;
        load = 1'b0;
        n_checks++;
        if (count_value !== 16'h0000 || carry_pulse !== 1'b0) begin
            n_fail++;
            $display("FAIL clear_over_load: cnt=%h cp=%b required 0000 0", count_value, carry_pulse);
        end
        for (int c = 1; c <= 4; c++) begin
            @(negedge clk);
            n_checks++;
            if (count_value !== 16'(c / 4)) begin
                n_fail++;
                $display("FAIL clear_restart c=%0d: cnt=%h required %h", c, count_value, 16'(c / 4));
            end
        end
    endtask

    task automatic test_scan();
        logic [3:0] want;
        en = 1'b0;
        load = 1'b1;
        load_value = 16'h1234;
        @(negedge clk);
        load = 1'b0;
        for (int c = 0; c < 2 * N * SD; c++) begin
            @(negedge clk);
            case (digit_sel)
                4'b0001: want = 4'd4;
                4'b0010: want = 4'd3;
                4'b0100: want = 4'd2;
                4'b1000: want = 4'd1;
                default: want = 4'hF;
            endcase
            n_checks++;
            if (number !== want || digit_sel !== exp_sel()) begin
                n_fail++;
                $display("FAIL scan_1234 c=%0d: sel=%b num=%0d required sel %b num %0d",
                         c, digit_sel, number, exp_sel(), exp_num());
            end
        end
        en = 1'b1;
        up = 1'b1;
        for (int c = 1; c <= TD; c++) begin
            @(negedge clk);
            n_checks++;
            if (count_value !== int_to_bcd(m_count) || number !== exp_num() || digit_sel !== exp_sel()) begin
                n_fail++;
                $display("FAIL scan_step c=%0d: cnt=%h sel=%b num=%0d required %h %b %0d",
                         c, count_value, digit_sel, number, int_to_bcd(m_count), exp_sel(), exp_num());
            end
        end
        case (digit_sel)
            4'b0001: want = 4'd5;
            4'b0010: want = 4'd3;
            4'b0100: want = 4'd2;
            4'b1000: want = 4'd1;
            default: want = 4'hF;
        endcase
        n_checks++;
        if (count_value !== 16'h1235 || number !== want) begin
            n_fail++;
            $display("FAIL scan_step_end: cnt=%h num=%0d required 1235 %0d", count_value, number, want);
        end
    endtask

    task automatic test_async_reset();
        en = 1'b0;
        load = 1'b1;
        load_value = 16'h0507;
        @(negedge clk);
        load = 1'b0;
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        n_checks++;
        if (count_value !== 16'h0000 || digit_sel !== 4'b0001 || number !== 4'd0 || carry_pulse !== 1'b0) begin
            n_fail++;
            $display("FAIL async_reset: cnt=%h sel=%b num=%0d cp=%b required 0000 0001 0 0",
                     count_value, digit_sel, number, carry_pulse);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        n_checks++;
        if (count_value !== 16'h0000 || digit_sel !== 4'b0001 || number !== 4'd0) begin
            n_fail++;
            $display("FAIL async_release: cnt=%h sel=%b num=%0d required 0000 0001 0",
                     count_value, digit_sel, number);
        end
    endtask

    task automatic test_random();
        for (int c = 0; c < 600; c++) begin
            en         = ($urandom_range(0, 7) != 0);
            up         = 1'($urandom_range(0, 1));
            clear      = ($urandom_range(0, 63) == 0);
            load       = ($urandom_range(0, 31) == 0);
            load_value = 16'($urandom);
            if ($urandom_range(0, 3) == 0) load_value = 16'h9999;
            if ($urandom_range(0, 3) == 0) load_value = 16'h0000;
            @(negedge clk);
            n_checks++;
            if (count_value !== int_to_bcd(m_count) || carry_pulse !== m_carry ||
                digit_sel !== exp_sel() || number !== exp_num()) begin
                n_fail++;
                $display("FAIL random c=%0d: cnt=%h cp=%b sel=%b num=%0d required %h %b %b %0d",
                         c, count_value, carry_pulse, digit_sel, number,
                         int_to_bcd(m_count), m_carry, exp_sel(), exp_num());
            end
        end
        clear = 1'b0;
        load  = 1'b0;
    endtask

    initial begin
        test_reset();
        test_wrap_up();
        test_down_hold();
        test_load_sat_clear();
        test_scan();
        test_async_reset();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/bcd_scan_counter.md
Name: bcd_scan_counter

Overview:
Multi-digit BCD counter with time-multiplexed output scanning; the stage directly upstream of the 7-segment digit decoder. Counts up or down at a prescaled rate and presents one digit value per scan slot on number. digit_sel selects the active display position for that slot. The decoder turns number into segment patterns; digit_sel drives the display common lines.

Parameters:
NUM_DIGITS, 4, number of BCD digits counted and scanned (1..8)
TICK_DIV, 50000, clk cycles per count step while en=1 (>=2)
SCAN_DIV, 1000, clk cycles per scan slot (>=2)

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
en  in  1  count enable; prescaler advances only while high
up  in  1  direction: 1 = increment, 0 = decrement; sampled on the tick cycle
clear  in  1  synchronous clear of count to all zeros
load  in  1  synchronous load of load_value
load_value  in  4*NUM_DIGITS  BCD value to load; digit 0 in bits [3:0]
number  out  4  BCD value of currently scanned digit, to decoder
digit_sel  out  NUM_DIGITS  one-hot active-high display position select
count_value  out  4*NUM_DIGITS  full current count, digit 0 in bits [3:0]
carry_pulse  out  1  one-cycle pulse on wrap (9..9->0..0 up, 0..0->9..9 down)

Behaviour:
- Reset (rst_n low, asynchronous): count all zeros, tick prescaler 0, scan prescaler 0, scan index 0, digit_sel = 1 (position 0), number = 0, carry_pulse = 0. Release takes effect at first clk edge with rst_n high.
- Tick prescaler: counts 0..TICK_DIV-1 only while en=1, holds while en=0. Tick fires on the cycle it equals TICK_DIV-1 with en=1, then returns to 0. First step after reset or clear/load comes TICK_DIV enabled cycles later.
- Priority per cycle: clear > load > tick step. clear or load also zero the tick prescaler. Neither produces carry_pulse.
- Load: each nibble > 9 is saturated to 9 on load. Other nibbles are loaded unchanged.
- Up step: digit 0 increments. A digit at 9 becomes 0 and carries into the next digit. All-nines wraps to all-zeros with carry_pulse = 1 in the following cycle.
- Down step: digit 0 decrements. A digit at 0 becomes 9 and borrows from the next digit. All-zeros wraps to all-nines with carry_pulse = 1 in the following cycle.
- carry_pulse is registered and high for exactly one cycle per wrap.
- count_value is registered. It reflects an update in the cycle after the tick, clear or load edge.
- Scan prescaler: free-running 0..SCAN_DIV-1 regardless of en, clear and load.
  - On wrap, scan index advances 0,1,..,NUM_DIGITS-1,0.
  - digit_sel = one-hot of the index; number = nibble[index] of the count.
  - Both are registered and update on the same edge, so they never disagree.
- number follows count changes within 1 cycle, even mid-slot.
- digit_sel is always exactly one-hot, including after reset and across wrap.
- Reset mid-scan or mid-count: all state returns to reset values immediately, with no partial step.
- NUM_DIGITS=1: digit_sel constant 1. Wrap behaviour applies to a single digit.

Test Plan:
1. Reset with NUM_DIGITS=4, TICK_DIV=4, SCAN_DIV=2, en=1, up=1 -> count_value 0x0000; steps every 4 cycles: 0x0001, 0x0002, ...; digit_sel cycles 0001,0010,0100,1000 every 2 cycles.
2. load_value=0x9998, then 2 ticks up -> 0x9999 then 0x0000; carry_pulse high exactly 1 cycle after the second step.
3. Load 0x0001, up=0 -> 0x0000 then 0x9999 with carry_pulse; en=0 for 20 cycles -> count holds at 0x9999, scan continues.
4. load_value=0xF3A2 -> count_value 0x9392 (invalid nibbles saturated); clear and load asserted together -> 0x0000, prescaler restarted.
5. Count 0x1234 while scanning -> per slot (digit_sel, number): (0001,4) (0010,3) (0100,2) (1000,1); a step mid-slot updates number the next cycle.
6. Assert rst_n low asynchronously mid-slot at count 0x0507 -> outputs immediately at reset values; digit_sel = 0001, number = 0.
